// File: rtl/bus_pkg.sv
// Shared bus definitions: default master parameters, master FSM states and
// arbiter state constants used by the bus masters and their arbiter.
package bus_pkg;

  localparam int BUS_AW_DEF    = 16;
  localparam int BUS_DW_DEF    = 16;
  localparam int BUS_TMO_DEF   = 15;
  localparam int BUS_MAX_BEATS = 4;
  localparam int BUS_TMO_W     = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_XFER = 2'd2,
    ST_REL  = 2'd3
  } mst_state_t;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_GNT0 = 2'd1,
    ARB_GNT1 = 2'd2
  } arb_state_t;

  // True when the beat just completed is the final beat of the command.
  function automatic logic is_last_beat(input logic [1:0] beat, input logic [1:0] len);
    return beat == len;
  endfunction

endpackage

// File: rtl/bus_tmo_cnt.sv
// Slave-response watchdog: counts stalled beat cycles and flags the cycle
// whose stall would bring the count up to the TMO limit.
module bus_tmo_cnt
  import bus_pkg::*;
#(
  parameter int TMO = BUS_TMO_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam logic [BUS_TMO_W-1:0] LAST = BUS_TMO_W'(TMO - 1);

  logic [BUS_TMO_W-1:0] cnt;

  // Expiry is flagged on the stalled cycle that completes the TMO-th wait,
  // so the master leaves XFER right after exactly TMO stalled cycles.
  assign expire = en && (cnt == LAST);

  // Count stalled cycles; clear has priority so a fresh beat starts from zero.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/bus_master_ctrl.sv
// Burst bus master: accepts a 1..4 beat read/write command, requests the bus
// from an arbiter, runs the beats with a per-beat timeout, then releases the
// bus for one cycle while reporting completion.
module bus_master_ctrl
  import bus_pkg::*;
#(
  parameter int AW  = BUS_AW_DEF,
  parameter int DW  = BUS_DW_DEF,
  parameter int TMO = BUS_TMO_DEF
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             cmd_valid,
  output logic                             cmd_ready,
  input  logic                             cmd_we,
  input  logic [AW-1:0]                    cmd_addr,
  input  logic [1:0]                       cmd_len,
  input  logic [BUS_MAX_BEATS*DW-1:0]      cmd_wdata,
  output logic                             rsp_valid,
  output logic [DW-1:0]                    rsp_rdata,
  output logic                             done,
  output logic                             err,
  output logic                             breq,
  input  logic                             bgrt,
  output logic                             bus_en,
  output logic                             bus_we,
  output logic [AW-1:0]                    bus_addr,
  output logic [DW-1:0]                    bus_wdata,
  input  logic [DW-1:0]                    bus_rdata,
  input  logic                             bus_ack
);

  mst_state_t                    state;
  logic                          lat_we;
  logic [AW-1:0]                 lat_addr;
  logic [1:0]                    lat_len;
  logic [BUS_MAX_BEATS*DW-1:0]   lat_wdata;
  logic [1:0]                    beat;
  logic                          beat_done;
  logic                          tmo_clr;
  logic                          tmo_en;
  logic                          tmo_expire;

  // The strobe follows the grant directly so a grant withdrawn mid-burst
  // stops the bus in the same cycle; ack without a strobe is never a beat.
  assign bus_en    = (state == ST_XFER) && bgrt;
  assign beat_done = bus_en && bus_ack;
  assign bus_we    = lat_we;
  assign bus_addr  = lat_addr + AW'(beat);
  assign bus_wdata = lat_wdata[beat*DW +: DW];

  // Wait counter runs only on stalled strobes inside XFER and restarts per beat.
  assign tmo_clr = (state != ST_XFER) || beat_done;
  assign tmo_en  = bus_en && !bus_ack;

  bus_tmo_cnt #(
    .TMO (TMO)
  ) u_tmo (
    .clk    (clk),
    .rst    (rst),
    .clr    (tmo_clr),
    .en     (tmo_en),
    .expire (tmo_expire)
  );

  // Master FSM with registered handshake, request, response and status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      cmd_ready <= 1'b1;
      breq      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_len   <= '0;
      lat_wdata <= '0;
      beat      <= '0;
    end else begin
      done      <= 1'b0;
      err       <= 1'b0;
      rsp_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cmd_valid && cmd_ready) begin
            lat_we    <= cmd_we;
            lat_addr  <= cmd_addr;
            lat_len   <= cmd_len;
            lat_wdata <= cmd_wdata;
            beat      <= '0;
            cmd_ready <= 1'b0;
            breq      <= 1'b1;
            state     <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (bgrt) begin
            state <= ST_XFER;
          end
        end
        ST_XFER: begin
          if (beat_done) begin
            if (!lat_we) begin
              rsp_valid <= 1'b1;
              rsp_rdata <= bus_rdata;
            end
            if (is_last_beat(beat, lat_len)) begin
              breq  <= 1'b0;
              done  <= 1'b1;
              state <= ST_REL;
            end else begin
              beat <= beat + 1'b1;
            end
          end else if (tmo_expire) begin
            breq  <= 1'b0;
            done  <= 1'b1;
            err   <= 1'b1;
            state <= ST_REL;
          end
        end
        ST_REL: begin
          cmd_ready <= 1'b1;
          state     <= ST_IDLE;
        end
        default: begin
          cmd_ready <= 1'b1;
          breq      <= 1'b0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_master_ctrl.sv
// Directed bench for bus_master_ctrl: single read, wrapping 4-beat write,
// timeout abort, reset mid-burst, and two masters sharing one arbiter.
module tb_bus_master_ctrl;
  import bus_pkg::*;

  localparam int AW = 16;
  localparam int DW = 16;

  logic clk = 1'b0;
  logic rst;

  logic          cmd_valid0, cmd_ready0, cmd_we0;
  logic [AW-1:0] cmd_addr0;
  logic [1:0]    cmd_len0;
  logic [4*DW-1:0] cmd_wdata0;
  logic          rsp_valid0, done0, err0, breq0, bgrt0, bus_en0, bus_we0;
  logic [DW-1:0] rsp_rdata0, bus_wdata0;
  logic [AW-1:0] bus_addr0;

  logic          cmd_valid1, cmd_ready1, cmd_we1;
  logic [AW-1:0] cmd_addr1;
  logic [1:0]    cmd_len1;
  logic [4*DW-1:0] cmd_wdata1;
  logic          rsp_valid1, done1, err1, breq1, bgrt1, bus_en1, bus_we1;
  logic [DW-1:0] rsp_rdata1, bus_wdata1;
  logic [AW-1:0] bus_addr1;

  logic [DW-1:0] bus_rdata;
  logic          ack0, ack1, tb_bgrt0, arb_mode;
  arb_state_t    arb_st;

  int errors = 0;
  int checks = 0;
  int rsp_cnt0 = 0;
  int done_cnt0 = 0;
  int done_cnt1 = 0;
  int en_cnt0 = 0;
  int en_cnt1 = 0;
  int overlap_cnt = 0;

  logic [15:0] wr_addr_exp [4] = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
  logic [15:0] wr_data_exp [4] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};

  assign bgrt0 = arb_mode ? (arb_st == ARB_GNT0) : tb_bgrt0;
  assign bgrt1 = arb_mode ? (arb_st == ARB_GNT1) : 1'b0;

  bus_master_ctrl #(.AW(AW), .DW(DW), .TMO(15)) u_m0 (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid0), .cmd_ready(cmd_ready0), .cmd_we(cmd_we0),
    .cmd_addr(cmd_addr0), .cmd_len(cmd_len0), .cmd_wdata(cmd_wdata0),
    .rsp_valid(rsp_valid0), .rsp_rdata(rsp_rdata0), .done(done0), .err(err0),
    .breq(breq0), .bgrt(bgrt0),
    .bus_en(bus_en0), .bus_we(bus_we0), .bus_addr(bus_addr0),
    .bus_wdata(bus_wdata0), .bus_rdata(bus_rdata), .bus_ack(ack0)
  );

  bus_master_ctrl #(.AW(AW), .DW(DW), .TMO(15)) u_m1 (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid1), .cmd_ready(cmd_ready1), .cmd_we(cmd_we1),
    .cmd_addr(cmd_addr1), .cmd_len(cmd_len1), .cmd_wdata(cmd_wdata1),
    .rsp_valid(rsp_valid1), .rsp_rdata(rsp_rdata1), .done(done1), .err(err1),
    .breq(breq1), .bgrt(bgrt1),
    .bus_en(bus_en1), .bus_we(bus_we1), .bus_addr(bus_addr1),
    .bus_wdata(bus_wdata1), .bus_rdata(bus_rdata), .bus_ack(ack1)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Fixed-priority arbiter that only hands over once the owner drops breq.
  always @(posedge clk) begin
    if (rst) begin
      arb_st <= ARB_IDLE;
    end else begin
      case (arb_st)
        ARB_IDLE: if (breq0) arb_st <= ARB_GNT0; else if (breq1) arb_st <= ARB_GNT1;
        ARB_GNT0: if (!breq0) arb_st <= breq1 ? ARB_GNT1 : ARB_IDLE;
        ARB_GNT1: if (!breq1) arb_st <= breq0 ? ARB_GNT0 : ARB_IDLE;
        default:  arb_st <= ARB_IDLE;
      endcase
    end
  end

  // Event counters sampled mid-cycle for pulse counts and bus overlap.
  always @(negedge clk) begin
    if (rsp_valid0) rsp_cnt0 <= rsp_cnt0 + 1;
    if (done0) done_cnt0 <= done_cnt0 + 1;
    if (done1) done_cnt1 <= done_cnt1 + 1;
    if (bus_en0) en_cnt0 <= en_cnt0 + 1;
    if (bus_en1) en_cnt1 <= en_cnt1 + 1;
    if (bus_en0 && bus_en1) overlap_cnt <= overlap_cnt + 1;
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Present one command to master 0 for a single cycle while it is idle.
  task automatic applyStimulus(input logic we, input logic [AW-1:0] addr,
                               input logic [1:0] len, input logic [4*DW-1:0] wdata);
    cmd_we0    = we;
    cmd_addr0  = addr;
    cmd_len0   = len;
    cmd_wdata0 = wdata;
    cmd_valid0 = 1'b1;
    tick();
    cmd_valid0 = 1'b0;
  endtask

  task automatic waitDone(input bit which, input int budget, input string tag, output int cycles);
    cycles = 0;
    while (((which ? done1 : done0) == 1'b0) && cycles < budget) begin
      tick();
      cycles++;
    end
    checkOutput({tag, "_done"}, 64'(which ? done1 : done0), 64'd1);
  endtask

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n, r0, d0, d1, o0, e0, e1;
    rst = 1'b1; arb_mode = 1'b0; tb_bgrt0 = 1'b0; ack0 = 1'b0; ack1 = 1'b0;
    bus_rdata = '0;
    cmd_valid0 = 1'b0; cmd_we0 = 1'b0; cmd_addr0 = '0; cmd_len0 = '0; cmd_wdata0 = '0;
    cmd_valid1 = 1'b0; cmd_we1 = 1'b0; cmd_addr1 = '0; cmd_len1 = '0; cmd_wdata1 = '0;
    repeat (3) tick();

    checkOutput("rst_cmd_ready", cmd_ready0, 1);
    checkOutput("rst_breq", breq0, 0);
    checkOutput("rst_bus_en", bus_en0, 0);
    checkOutput("rst_rsp_valid", rsp_valid0, 0);
    checkOutput("rst_done", done0, 0);
    checkOutput("rst_err", err0, 0);
    checkOutput("rst_bus_addr", bus_addr0, 0);
    checkOutput("rst_bus_wdata", bus_wdata0, 0);
    checkOutput("rst_rsp_rdata", rsp_rdata0, 0);
    rst = 1'b0;
    tick();

    // Single read with a delayed grant.
    r0 = rsp_cnt0;
    applyStimulus(1'b0, 16'h0100, 2'd0, '0);
    checkOutput("rd_breq", breq0, 1);
    checkOutput("rd_cmd_ready", cmd_ready0, 0);
    tick();
    checkOutput("rd_wait_breq", breq0, 1);
    checkOutput("rd_wait_en", bus_en0, 0);
    tb_bgrt0 = 1'b1;
    tick();
    checkOutput("rd_en", bus_en0, 1);
    checkOutput("rd_addr", bus_addr0, 16'h0100);
    checkOutput("rd_we", bus_we0, 0);
    ack0 = 1'b1; bus_rdata = 16'hBEEF;
    tick();
    ack0 = 1'b0; bus_rdata = '0; tb_bgrt0 = 1'b0;
    checkOutput("rd_rsp_valid", rsp_valid0, 1);
    checkOutput("rd_rsp_rdata", rsp_rdata0, 16'hBEEF);
    checkOutput("rd_done", done0, 1);
    checkOutput("rd_err", err0, 0);
    checkOutput("rd_rel_breq", breq0, 0);
    tick();
    checkOutput("rd_done_pulse", done0, 0);
    checkOutput("rd_idle_breq", breq0, 0);
    checkOutput("rd_idle_ready", cmd_ready0, 1);
    tick();
    checkOutput("rd_rsp_count", rsp_cnt0 - r0, 1);

    // Wrapping 4-beat write with a grant drop and a slave stall.
    r0 = rsp_cnt0;
    tb_bgrt0 = 1'b1;
    applyStimulus(1'b1, 16'hFFFE, 2'd3, 64'h4444_3333_2222_1111);
    tick();
    for (int i = 0; i < 4; i++) begin
      if (i == 1) begin
        tb_bgrt0 = 1'b0; ack0 = 1'b1; #1;
        checkOutput("wr_nogrant_en", bus_en0, 0);
        tick();
        tb_bgrt0 = 1'b1; #1;
      end
      if (i == 2) begin
        ack0 = 1'b0;
        tick();
      end
      checkOutput($sformatf("wr_en%0d", i), bus_en0, 1);
      checkOutput($sformatf("wr_we%0d", i), bus_we0, 1);
      checkOutput($sformatf("wr_addr%0d", i), bus_addr0, wr_addr_exp[i]);
      checkOutput($sformatf("wr_data%0d", i), bus_wdata0, wr_data_exp[i]);
      ack0 = 1'b1;
      tick();
    end
    ack0 = 1'b0; tb_bgrt0 = 1'b0;
    checkOutput("wr_done", done0, 1);
    checkOutput("wr_err", err0, 0);
    checkOutput("wr_rel_breq", breq0, 0);
    tick();
    checkOutput("wr_done_pulse", done0, 0);
    tick();
    checkOutput("wr_rsp_count", rsp_cnt0 - r0, 0);

    // Timeout on a read that is never acknowledged.
    r0 = rsp_cnt0;
    tb_bgrt0 = 1'b1; ack0 = 1'b0;
    applyStimulus(1'b0, 16'h0400, 2'd3, '0);
    tick();
    checkOutput("tmo_en", bus_en0, 1);
    n = 0;
    while (!done0 && n < 40) begin
      n++;
      tick();
    end
    checkOutput("tmo_cycles", n, 15);
    checkOutput("tmo_done", done0, 1);
    checkOutput("tmo_err", err0, 1);
    tb_bgrt0 = 1'b0;
    tick();
    checkOutput("tmo_err_clear", err0, 0);
    checkOutput("tmo_done_clear", done0, 0);
    tick();
    checkOutput("tmo_rsp_count", rsp_cnt0 - r0, 0);

    // Reset on the second beat of a 4-beat write, then a normal read.
    d0 = done_cnt0;
    tb_bgrt0 = 1'b1; ack0 = 1'b1;
    applyStimulus(1'b1, 16'h0200, 2'd3, 64'hDDDD_CCCC_BBBB_AAAA);
    tick();
    tick();
    checkOutput("rstmid_addr", bus_addr0, 16'h0201);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("rstmid_breq", breq0, 0);
    checkOutput("rstmid_bus_en", bus_en0, 0);
    checkOutput("rstmid_ready", cmd_ready0, 1);
    checkOutput("rstmid_done", done0, 0);
    ack0 = 1'b0;
    repeat (3) tick();
    checkOutput("rstmid_no_done", done_cnt0 - d0, 0);
    r0 = rsp_cnt0;
    ack0 = 1'b1; bus_rdata = 16'h1234;
    applyStimulus(1'b0, 16'h0300, 2'd1, '0);
    waitDone(1'b0, 20, "post_rst", n);
    checkOutput("post_rst_err", err0, 0);
    checkOutput("post_rst_rsp_valid", rsp_valid0, 1);
    checkOutput("post_rst_rdata", rsp_rdata0, 16'h1234);
    ack0 = 1'b0; tb_bgrt0 = 1'b0; bus_rdata = '0;
    tick();
    tick();
    checkOutput("post_rst_rsp_count", rsp_cnt0 - r0, 2);

    // Two masters contend through the arbiter with an always-ready slave.
    rst = 1'b1; arb_mode = 1'b1; ack0 = 1'b1; ack1 = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    o0 = overlap_cnt; d0 = done_cnt0; d1 = done_cnt1; e0 = en_cnt0; e1 = en_cnt1;
    cmd_we0 = 1'b1; cmd_addr0 = 16'h0010; cmd_len0 = 2'd1; cmd_wdata0 = 64'h0000_0000_00B2_00B1;
    cmd_we1 = 1'b1; cmd_addr1 = 16'h0020; cmd_len1 = 2'd1; cmd_wdata1 = 64'h0000_0000_00C2_00C1;
    cmd_valid0 = 1'b1; cmd_valid1 = 1'b1;
    tick();
    cmd_valid0 = 1'b0; cmd_valid1 = 1'b0;
    waitDone(1'b0, 30, "arb_m0", n);
    checkOutput("arb_m0_breq_low", breq0, 0);
    checkOutput("arb_m1_waiting", breq1, 1);
    checkOutput("arb_m1_not_done", done_cnt1 - d1, 0);
    waitDone(1'b1, 30, "arb_m1", n);
    checkOutput("arb_m1_err", err1, 0);
    tick();
    checkOutput("arb_overlap", overlap_cnt - o0, 0);
    checkOutput("arb_m0_done_count", done_cnt0 - d0, 1);
    checkOutput("arb_m0_beats", en_cnt0 - e0, 2);
    checkOutput("arb_m1_beats", en_cnt1 - e1, 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
